// File: rtl/bus_arbiter.sv
// Two-cache to single-memory bus arbiter with round-robin fairness and a
// per-grant completion watchdog that latches a sticky error.
module bus_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned IOS_W   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IOS_W-1:0]  rw0,
  input  logic [IOS_W-1:0]  rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WORD_W-1:0] data0,
  input  logic [WORD_W-1:0] data1,
  output logic              readEn0,
  output logic              readEn1,
  output logic              writeDone0,
  output logic              writeDone1,
  output logic [WORD_W-1:0] dataToCache,
  output logic [IOS_W-1:0]  rwToMem,
  output logic [ADDR_W-1:0] addrToMem,
  output logic [WORD_W-1:0] dataToMem,
  input  logic [WORD_W-1:0] dataFromMem,
  input  logic              readEnFromMem,
  input  logic              writeDoneFromMem,
  output logic              grant0,
  output logic              grant1,
  output logic              timeoutErr
);

  // Command codes shared with the caches and memory.
  localparam logic [IOS_W-1:0] IDEL = IOS_W'(0);
  localparam logic [IOS_W-1:0] RD   = IOS_W'(1);
  localparam logic [IOS_W-1:0] WT   = IOS_W'(2);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state, stateNext;
  logic              ptr, ptrNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [IOS_W-1:0]  rwNext;
  logic [ADDR_W-1:0] addrNext;
  logic [WORD_W-1:0] dataNext;
  logic              grant0Next, grant1Next, errNext;
  logic              req0, req1, done;

  // Only RD and WT count as a request; every other code behaves as IDEL.
  assign req0 = (rw0 == RD) || (rw0 == WT);
  assign req1 = (rw1 == RD) || (rw1 == WT);

  // Read data is passed straight through to both caches.
  assign dataToCache = dataFromMem;

  // Completion uses only the strobe matching the latched command.
  assign done = ((state == OWN0) || (state == OWN1)) &&
                (((rwToMem == RD) && readEnFromMem) ||
                 ((rwToMem == WT) && writeDoneFromMem));

  // Next-state, next-register values and combinational completion pulses.
  always_comb begin
    stateNext  = state;
    ptrNext    = ptr;
    cntNext    = cnt;
    rwNext     = rwToMem;
    addrNext   = addrToMem;
    dataNext   = dataToMem;
    grant0Next = grant0;
    grant1Next = grant1;
    errNext    = timeoutErr;
    readEn0    = 1'b0;
    readEn1    = 1'b0;
    writeDone0 = 1'b0;
    writeDone1 = 1'b0;

    case (state)
      IDLE: begin
        if (req0 && (!req1 || !ptr)) begin
          stateNext  = OWN0;
          rwNext     = rw0;
          addrNext   = addr0;
          dataNext   = data0;
          grant0Next = 1'b1;
          cntNext    = '0;
        end else if (req1) begin
          stateNext  = OWN1;
          rwNext     = rw1;
          addrNext   = addr1;
          dataNext   = data1;
          grant1Next = 1'b1;
          cntNext    = '0;
        end
      end
      OWN0, OWN1: begin
        if (done) begin
          // Reset suppresses the pulse; the register path is overridden anyway.
          if (!reset) begin
            if (state == OWN0) begin
              readEn0    = (rwToMem == RD);
              writeDone0 = (rwToMem == WT);
            end else begin
              readEn1    = (rwToMem == RD);
              writeDone1 = (rwToMem == WT);
            end
          end
          stateNext  = IDLE;
          rwNext     = IDEL;
          grant0Next = 1'b0;
          grant1Next = 1'b0;
          ptrNext    = (state == OWN0);
        end else if (cnt == CNT_MAX) begin
          stateNext  = ERR;
          rwNext     = IDEL;
          grant0Next = 1'b0;
          grant1Next = 1'b0;
          errNext    = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      ERR: begin
        stateNext = ERR;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      cnt        <= '0;
      rwToMem    <= IDEL;
      addrToMem  <= '0;
      dataToMem  <= '0;
      grant0     <= 1'b0;
      grant1     <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= stateNext;
      ptr        <= ptrNext;
      cnt        <= cntNext;
      rwToMem    <= rwNext;
      addrToMem  <= addrNext;
      dataToMem  <= dataNext;
      grant0     <= grant0Next;
      grant1     <= grant1Next;
      timeoutErr <= errNext;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single read, contention, fairness, wrong
// strobe, timeout into ERR, and reset during a completion.
module tb_bus_arbiter;

  localparam logic [1:0] IDEL = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WT   = 2'd2;

  logic        clk;
  logic        reset;
  logic [1:0]  rw0, rw1;
  logic [7:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic        readEn0, readEn1, writeDone0, writeDone1;
  logic [31:0] dataToCache;
  logic [1:0]  rwToMem;
  logic [7:0]  addrToMem;
  logic [31:0] dataToMem;
  logic [31:0] dataFromMem;
  logic        readEnFromMem, writeDoneFromMem;
  logic        grant0, grant1, timeoutErr;

  int vectors;
  int miscompares;

  bus_arbiter #(
    .ADDR_W(8), .WORD_W(32), .IOS_W(2), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .readEn0(readEn0), .readEn1(readEn1),
    .writeDone0(writeDone0), .writeDone1(writeDone1),
    .dataToCache(dataToCache), .rwToMem(rwToMem),
    .addrToMem(addrToMem), .dataToMem(dataToMem),
    .dataFromMem(dataFromMem), .readEnFromMem(readEnFromMem),
    .writeDoneFromMem(writeDoneFromMem),
    .grant0(grant0), .grant1(grant1), .timeoutErr(timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; checks run 1 time unit later.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic noPulses(input string tag);
    chkb({tag, "_rE0"}, readEn0, 1'b0);
    chkb({tag, "_rE1"}, readEn1, 1'b0);
    chkb({tag, "_wD0"}, writeDone0, 1'b0);
    chkb({tag, "_wD1"}, writeDone1, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    rw0 = IDEL; rw1 = IDEL;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    dataFromMem = '0; readEnFromMem = 1'b0; writeDoneFromMem = 1'b0;

    nxt(); nxt();
    // Reset state
    #1;
    chkb("rst_g0", grant0, 1'b0);
    chkb("rst_g1", grant1, 1'b0);
    chk ("rst_rw", 32'(rwToMem), 32'(IDEL));
    chk ("rst_addr", 32'(addrToMem), 32'h0);
    chk ("rst_data", dataToMem, 32'h0);
    chkb("rst_err", timeoutErr, 1'b0);
    noPulses("rst");

    // Single read from cache 0
    nxt();
    reset = 1'b0; rw0 = RD; addr0 = 8'h12; data0 = 32'hA5A5A5A5;
    #1 chkb("rd_g0_pre", grant0, 1'b0);
    nxt();
    rw0 = IDEL; addr0 = 8'h99;  // dropping the request must not disturb the grant
    #1;
    chkb("rd_g0", grant0, 1'b1);
    chkb("rd_g1", grant1, 1'b0);
    chk ("rd_rw", 32'(rwToMem), 32'(RD));
    chk ("rd_addr", 32'(addrToMem), 32'h12);
    noPulses("rd_wait0");
    nxt();
    writeDoneFromMem = 1'b1;  // wrong strobe for a read
    #1 noPulses("rd_wrong");
    nxt();
    writeDoneFromMem = 1'b0;
    #1;
    chkb("rd_held_g0", grant0, 1'b1);
    chk ("rd_held_addr", 32'(addrToMem), 32'h12);
    nxt();
    readEnFromMem = 1'b1; dataFromMem = 32'hDEADBEEF;
    #1;
    chkb("rd_done_rE0", readEn0, 1'b1);
    chkb("rd_done_rE1", readEn1, 1'b0);
    chkb("rd_done_wD0", writeDone0, 1'b0);
    chk ("rd_done_data", dataToCache, 32'hDEADBEEF);
    nxt();
    readEnFromMem = 1'b0;
    #1;
    chk ("rd_after_rw", 32'(rwToMem), 32'(IDEL));
    chkb("rd_after_g0", grant0, 1'b0);
    chkb("rd_after_rE0", readEn0, 1'b0);

    // Contention from reset: cache 0 first, then cache 1 after one IDLE cycle
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    rw0 = WT; addr0 = 8'h20; data0 = 32'h11111111;
    rw1 = RD; addr1 = 8'h30; data1 = 32'h22222222;
    #1 chkb("ct_g0_pre", grant0, 1'b0);
    nxt();
    readEnFromMem = 1'b1; writeDoneFromMem = 1'b1;  // both strobes: write completes only
    #1;
    chkb("ct_g0", grant0, 1'b1);
    chkb("ct_g1", grant1, 1'b0);
    chk ("ct_rw", 32'(rwToMem), 32'(WT));
    chk ("ct_addr", 32'(addrToMem), 32'h20);
    chk ("ct_data", dataToMem, 32'h11111111);
    chkb("ct_wD0", writeDone0, 1'b1);
    chkb("ct_rE0", readEn0, 1'b0);
    chkb("ct_rE1", readEn1, 1'b0);
    chkb("ct_wD1", writeDone1, 1'b0);
    nxt();
    readEnFromMem = 1'b0; writeDoneFromMem = 1'b0;
    #1;
    chkb("ct_turn_g0", grant0, 1'b0);
    chkb("ct_turn_g1", grant1, 1'b0);
    chk ("ct_turn_rw", 32'(rwToMem), 32'(IDEL));
    nxt();
    readEnFromMem = 1'b1; dataFromMem = 32'hCAFEF00D;
    #1;
    chkb("fair_g1", grant1, 1'b1);
    chkb("fair_g0", grant0, 1'b0);
    chk ("fair_addr", 32'(addrToMem), 32'h30);
    chk ("fair_rw", 32'(rwToMem), 32'(RD));
    chk ("fair_data", dataToMem, 32'h22222222);
    chkb("fair_rE1", readEn1, 1'b1);
    chkb("fair_rE0", readEn0, 1'b0);
    chk ("fair_dtc", dataToCache, 32'hCAFEF00D);
    rw1 = IDEL;
    nxt();
    readEnFromMem = 1'b0;
    #1 chkb("fair_after_g1", grant1, 1'b0);

    // Cache 0 write granted again, then memory never answers: timeout
    nxt();
    rw0 = IDEL;
    #1;
    chkb("to_g0", grant0, 1'b1);
    chk ("to_addr", 32'(addrToMem), 32'h20);
    nxt();
    rw1 = RD; addr1 = 8'h31;
    nxt();
    readEnFromMem = 1'b1;  // wrong strobe for a write; non-owner gets nothing
    #1;
    noPulses("to_wrong");
    chkb("to_g1_wait", grant1, 1'b0);
    nxt();
    readEnFromMem = 1'b0;
    nxt();
    #1;
    chkb("to_last_g0", grant0, 1'b1);
    chkb("to_last_err", timeoutErr, 1'b0);
    nxt();
    #1;
    chkb("to_err", timeoutErr, 1'b1);
    chkb("to_err_g0", grant0, 1'b0);
    chkb("to_err_g1", grant1, 1'b0);
    chk ("to_err_rw", 32'(rwToMem), 32'(IDEL));
    nxt();
    writeDoneFromMem = 1'b1; readEnFromMem = 1'b1;
    #1;
    chkb("err_hold", timeoutErr, 1'b1);
    chkb("err_g1", grant1, 1'b0);
    noPulses("err");

    // Reset in the same cycle as a read completion
    reset = 1'b1;
    writeDoneFromMem = 1'b0; readEnFromMem = 1'b0;
    nxt();
    reset = 1'b0; rw1 = IDEL;
    rw0 = RD; addr0 = 8'h44; data0 = 32'h00000005;
    #1;
    chkb("rr_err_clr", timeoutErr, 1'b0);
    chkb("rr_g0_pre", grant0, 1'b0);
    nxt();
    reset = 1'b1; readEnFromMem = 1'b1;
    #1;
    chkb("rr_g0", grant0, 1'b1);
    chk ("rr_addr", 32'(addrToMem), 32'h44);
    chk ("rr_data", dataToMem, 32'h5);
    chkb("rr_rE0", readEn0, 1'b0);
    nxt();
    reset = 1'b0; readEnFromMem = 1'b0;
    rw0 = RD; rw1 = RD; addr1 = 8'h55;
    #1;
    chkb("rr_after_g0", grant0, 1'b0);
    chk ("rr_after_rw", 32'(rwToMem), 32'(IDEL));
    chk ("rr_after_addr", 32'(addrToMem), 32'h0);
    chk ("rr_after_data", dataToMem, 32'h0);
    chkb("rr_after_err", timeoutErr, 1'b0);
    noPulses("rr_after");
    nxt();
    #1;
    chkb("rr_ptr_g0", grant0, 1'b1);
    chkb("rr_ptr_g1", grant1, 1'b0);
    chk ("rr_ptr_addr", 32'(addrToMem), 32'h44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width (matches `ADDRWIDTH).
REQ-002 SHALL have parameter WORD_W, default 32, data word width (matches `WORDWIDTH).
REQ-003 SHALL have parameter IOS_W, default 2, width of the rw code (matches `IOSTATEWIDTH); IDEL, RD and WT are the codes from def.v.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum number of cycles a grant may wait for memory completion.
REQ-005 SHALL have these ports:
- clk  in  1  sole clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- rw0, rw1  in  IOS_W  request code from cache 0 / cache 1.
- addr0, addr1  in  ADDR_W  request address.
- data0, data1  in  WORD_W  write data.
- readEn0, readEn1  out  1  read-complete pulse to the owning cache.
- writeDone0, writeDone1  out  1  write-complete pulse to the owning cache.
- dataToCache  out  WORD_W  equals dataFromMem, shared by both caches.
- rwToMem  out  IOS_W  registered memory command.
- addrToMem  out  ADDR_W  registered memory address.
- dataToMem  out  WORD_W  registered memory write data.
- dataFromMem  in  WORD_W  memory read data.
- readEnFromMem  in  1  memory read complete.
- writeDoneFromMem  in  1  memory write complete.
- grant0, grant1  out  1  current bus owner; one-hot or both zero.
- timeoutErr  out  1  sticky error flag.

Function
REQ-006 A cache SHALL be treated as requesting when its rw is not IDEL; any other non-RD/WT code is also treated as IDEL.
REQ-007 SHALL implement states IDLE, OWN0, OWN1 and ERR.
REQ-008 In IDLE with exactly one requester, SHALL move to that requester's OWN state on the next edge.
REQ-009 In IDLE with both caches requesting, SHALL grant the cache indicated by the round-robin pointer.
- The pointer resets to cache 0.
- After each completed transaction the pointer moves to the cache that was not just served.
REQ-010 On the IDLE->OWNx edge, SHALL latch rwx, addrx and datax into rwToMem, addrToMem and dataToMem, and SHALL assert grantx.
- All four are registered and valid from the cycle after the request is sampled.
- They are held constant for the whole ownership.
REQ-011 In OWNx, completion SHALL be readEnFromMem when the latched command is RD, or writeDoneFromMem when it is WT.
- The non-matching strobe is ignored.
- If both strobes are high, only the matching one counts.
REQ-012 In the completion cycle, SHALL combinationally assert readEnx or writeDonex to the owner only.
- On the next edge, return to IDLE, set rwToMem to IDEL, deassert grants and update the pointer.
REQ-013 The earliest next grant SHALL be two cycles after completion; the IDLE turnaround cycle is mandatory.
REQ-014 The requester changing or dropping its rw during ownership SHALL NOT abort or alter the latched transaction.
REQ-015 The non-owner's request SHALL wait, and it receives no readEn or writeDone pulses.
REQ-016 A wait counter SHALL clear on entry to OWNx and increment on each non-completion cycle.
- If it reaches TIMEOUT, go to ERR: timeoutErr=1, rwToMem=IDEL, grants=0.
- ERR persists until reset.
- A completion arriving in the same cycle that the counter reaches TIMEOUT wins: normal completion, no error.
REQ-017 Memory strobes SHALL be ignored in IDLE and ERR.
REQ-018 readEn0/1 and writeDone0/1 SHALL be low in every cycle except a completion cycle.

Reset
REQ-019 While reset is high at a clock edge, SHALL enter IDLE with:
- pointer to cache 0;
- counter 0;
- rwToMem=IDEL, addrToMem=0, dataToMem=0;
- grants=0, timeoutErr=0.
REQ-020 Reset SHALL take precedence over every other event, including mid-ownership and completion in the same cycle.
- The in-flight transaction is dropped without any completion pulse.
REQ-021 readEn0/1 and writeDone0/1 SHALL be 0 in any cycle where reset is high.

Verification
REQ-022 Single read: rw0=RD, addr0=0x12 in IDLE; next cycle grant0=1, rwToMem=RD, addrToMem=0x12; memory returns readEnFromMem=1 with 0xDEADBEEF three cycles later -> readEn0=1 and dataToCache=0xDEADBEEF that cycle, rwToMem=IDEL next cycle.
REQ-023 Contention: rw0=WT and rw1=RD both asserted from reset -> cache 0 served first; after its writeDone, one IDLE cycle, then grant1=1 with addrToMem=addr1.
REQ-024 Fairness: cache 0 re-requests immediately after being served while cache 1 is still waiting -> cache 1 is granted next.
REQ-025 Wrong strobe: RD grant receives writeDoneFromMem=1 -> no pulses, ownership held; a later readEnFromMem completes normally.
REQ-026 Timeout: TIMEOUT=4, RD grant with no memory response -> ERR entered after 4 wait cycles with timeoutErr=1 and rwToMem=IDEL; new requests are ignored until reset.
REQ-027 Reset mid-ownership: reset asserted in the same cycle as readEnFromMem -> readEn0 stays 0; next cycle IDLE with all outputs at reset values.
